// File: rtl/audio_pkg.sv
// audio_pkg
//   Shared definitions for audio_out_stage: DAC midscale code, fade gain
//   range and width, the playback FSM state type, and the fade scaling
//   helper. The helper is referenced only when AUDIO_FADE_EN is defined.
package audio_pkg;

  localparam logic [7:0]  MIDSCALE = 8'h80;
  localparam int unsigned GAIN_MAX = 16;
  localparam int unsigned GAIN_W   = 5;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_PLAY = 1'b1
  } audio_state_e;

  // 128 + (((s - 128) * gain) >>> 4), evaluated signed at 13 bits and
  // clamped to the 8-bit DAC range.
  function automatic logic [7:0] fade_scale(input logic [7:0]        sample,
                                            input logic [GAIN_W-1:0] gain);
    logic signed [12:0] diff;
    logic signed [12:0] prod;
    logic signed [12:0] res;
    diff = $signed({5'b0, sample}) - 13'sd128;
    prod = diff * $signed({8'b0, gain});
    res  = (prod >>> 4) + 13'sd128;
    if (res < 13'sd0) begin
      return 8'h00;
    end else if (res > 13'sd255) begin
      return 8'hFF;
    end else begin
      return res[7:0];
    end
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo
//   Circular sample buffer between the tone generator and the DAC stage.
//   Pointers wrap modulo DEPTH (power of two, >= 2). A push while full or
//   a pop while empty is ignored, so the level stays within 0..DEPTH.
//   Simultaneous push and pop leave the level unchanged.
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write strobe and sample
//   i_pop          : read strobe (advances the read pointer)
//   o_data         : sample at the head of the buffer
//   o_level        : number of buffered samples
//   o_empty        : level is zero
module audio_sample_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage carries no reset; stale entries are unreachable once the
  // pointers and level are cleared.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/audio_out_stage.sv
// audio_out_stage
//   Paces buffered 8-bit samples out to an R-2R DAC at a fixed sample rate.
//   A divider produces a tick every SAMPLE_DIV+1 cycles. The FSM waits in
//   FILL until PRIME_LVL samples are buffered, then pops one sample per tick
//   in PLAY; a tick in PLAY with an empty buffer pulses underrun, holds the
//   DAC value and returns to FILL.
//   Optional feature macro: AUDIO_FADE_EN. When defined, mute ramps a 0..16
//   gain per popping tick instead of forcing midscale.
// Ports
//   CLOCK_25             : system clock
//   reset_n              : asynchronous active-low reset (deassertion is
//                          expected to be synchronous to CLOCK_25)
//   s_data/s_valid/s_ready : sample input handshake
//   mute                 : level-sensitive mute request
//   dac_out              : registered DAC code
//   sample_tick          : one-cycle pulse at each sample instant
//   underrun             : one-cycle pulse on a PLAY tick with empty buffer
//   fifo_level           : buffered sample count
module audio_out_stage
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 200,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PRIME_LVL  = 2
) (
  input  logic                          CLOCK_25,
  input  logic                          reset_n,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          mute,
  output logic [7:0]                    dac_out,
  output logic                          sample_tick,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 0) ? $clog2(SAMPLE_DIV + 1) : 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DIV_W-1:0] r_div;
  audio_state_e     r_state;
  audio_state_e     w_state_nxt;
  logic [7:0]       r_dac;
  logic [7:0]       w_dac_nxt;
  logic [7:0]       w_fifo_data;
  logic             w_fifo_empty;
  logic             w_tick;
  logic             w_push;
  logic             w_pop;
  logic             w_underrun;

  // Sample-rate divider: the tick is the cycle in which the count is zero.
  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= DIV_W'(SAMPLE_DIV);
    end else if (r_div == '0) begin
      r_div <= DIV_W'(SAMPLE_DIV);
    end else begin
      r_div <= r_div - DIV_W'(1);
    end
  end

  assign w_tick  = (r_div == '0);
  assign s_ready = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign w_push  = s_valid && s_ready;

  audio_sample_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .i_clk   (CLOCK_25),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_data  (s_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_level (fifo_level),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Level is sampled before any same-cycle push, so a push into an empty
  // buffer on a tick does not bypass to the DAC. PRIME_LVL >= 1 guarantees
  // the priming tick finds data.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_underrun  = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_FILL: begin
          if (fifo_level >= LVL_W'(PRIME_LVL)) begin
            w_state_nxt = ST_PLAY;
            w_pop       = 1'b1;
          end
        end
        ST_PLAY: begin
          if (w_fifo_empty) begin
            w_state_nxt = ST_FILL;
            w_underrun  = 1'b1;
          end else begin
            w_pop = 1'b1;
          end
        end
        default: w_state_nxt = ST_FILL;
      endcase
    end
  end

`ifdef AUDIO_FADE_EN
  logic [GAIN_W-1:0] r_gain;

  // Gain moves one step per popping tick; the popped sample is scaled by
  // the gain in force before that step.
  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_gain <= GAIN_W'(GAIN_MAX);
    end else if (w_pop) begin
      if (mute) begin
        if (r_gain != '0) begin
          r_gain <= r_gain - GAIN_W'(1);
        end
      end else if (r_gain != GAIN_W'(GAIN_MAX)) begin
        r_gain <= r_gain + GAIN_W'(1);
      end
    end
  end

  assign w_dac_nxt = fade_scale(w_fifo_data, r_gain);
`else
  // Muted pops still drain the buffer; the sample is discarded.
  assign w_dac_nxt = mute ? MIDSCALE : w_fifo_data;
`endif

  // The DAC only changes on a popping tick, so it holds through FILL and
  // across an underrun.
  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_dac <= MIDSCALE;
    end else if (w_pop) begin
      r_dac <= w_dac_nxt;
    end
  end

  assign dac_out     = r_dac;
  assign sample_tick = w_tick;
  assign underrun    = w_underrun;

endmodule

// File: tb/tb_audio_out_stage.sv
// tb_audio_out_stage
//   Directed scenarios plus a randomized run for audio_out_stage (default
//   build, AUDIO_FADE_EN undefined). Expected values come from a queue-based
//   model of the sample buffer and playback rules, stepped once per clock.
module tb_audio_out_stage;

  localparam int unsigned DIV   = 200;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PRIME = 2;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          CLOCK_25 = 1'b0;
  logic          reset_n  = 1'b0;
  logic [7:0]    s_data   = 8'h00;
  logic          s_valid  = 1'b0;
  logic          mute     = 1'b0;
  logic          s_ready;
  logic [7:0]    dac_out;
  logic          sample_tick;
  logic          underrun;
  logic [LW-1:0] fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] bb_data [5];

  always #20 CLOCK_25 = ~CLOCK_25;

  audio_out_stage #(
    .SAMPLE_DIV (DIV),
    .FIFO_DEPTH (DEPTH),
    .PRIME_LVL  (PRIME)
  ) dut (
    .CLOCK_25    (CLOCK_25),
    .reset_n     (reset_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .mute        (mute),
    .dac_out     (dac_out),
    .sample_tick (sample_tick),
    .underrun    (underrun),
    .fifo_level  (fifo_level)
  );

  // ---------------- reference model ----------------
  byte unsigned m_q[$];
  bit           m_play;
  logic [7:0]   m_dac;
  int unsigned  m_n;     // rising edges since reset release

  function automatic bit m_tick();
    return (m_n % (DIV + 1)) == DIV;
  endfunction

  function automatic bit m_und();
    return m_tick() && m_play && (m_q.size() == 0);
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_play = 1'b0;
    m_dac  = 8'h80;
    m_n    = 0;
  endfunction

  // Effect of the coming rising edge given the inputs currently driven.
  function automatic void model_edge();
    int unsigned  pre;
    byte unsigned v;
    if (!reset_n) begin
      model_reset();
      return;
    end
    pre = m_q.size();
    if (m_tick()) begin
      if (m_play && pre == 0) begin
        m_play = 1'b0;
      end else if (m_play || pre >= PRIME) begin
        m_play = 1'b1;
        v      = m_q.pop_front();
        m_dac  = mute ? 8'h80 : v;
      end
    end
    if (s_valid && pre < DEPTH) m_q.push_back(s_data);
    m_n++;
  endfunction

  // Advance one clock; sampling point is 1 time unit after the falling edge.
  task automatic next_cycle();
    model_edge();
    @(negedge CLOCK_25);
    #1;
  endtask

  task automatic wait_tick();
    int k = 0;
    while (!m_tick() && k < 2 * (DIV + 1)) begin
      next_cycle();
      k++;
    end
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    mute    = 1'b0;
    s_data  = 8'h00;
    reset_n = 1'b0;
    #1;
    model_reset();
    repeat (3) next_cycle();
    reset_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; s_valid = 1'b0; mute = 1'b0; s_data = 8'h00;
    #1;
    model_reset();
    n_tests++; if (dac_out !== 8'h80) begin n_fail++; $display("FAIL reset_dac: got %h expected 80", dac_out); end
    n_tests++; if (sample_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", sample_tick); end
    n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    n_tests++; if (fifo_level !== LW'(0)) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", s_ready); end
    repeat (3) next_cycle();
    reset_n = 1'b1;
  endtask

  // Called right after reset release: the current sample point is cycle 1.
  task automatic test_idle_ticks();
    int tk[$];
    for (int c = 1; c <= 1000; c++) begin
      n_tests++;
      if (sample_tick !== (((c - 1) % (DIV + 1)) == DIV)) begin
        n_fail++; $display("FAIL idle_tick cycle %0d: got %b", c, sample_tick);
      end
      n_tests++;
      if (dac_out !== 8'h80 || underrun !== 1'b0) begin
        n_fail++; $display("FAIL idle_out cycle %0d: dac %h underrun %b expected 80/0", c, dac_out, underrun);
      end
      if (sample_tick === 1'b1) tk.push_back(c);
      next_cycle();
    end
    n_tests++;
    if (tk.size() != 4 || tk[0] != 201 || tk[1] != 402 || tk[2] != 603 || tk[3] != 804) begin
      n_fail++; $display("FAIL idle_tick_cycles: got %0d ticks, first %0d expected 201,402,603,804",
                         tk.size(), (tk.size() > 0) ? tk[0] : -1);
    end
  endtask

  task automatic test_play_basic();
    do_reset();
    s_valid = 1'b1; s_data = 8'h10; next_cycle();
    s_data = 8'hF0; next_cycle();
    s_valid = 1'b0;
    n_tests++; if (fifo_level !== LW'(2)) begin n_fail++; $display("FAIL basic_level: got %0d expected 2", fifo_level); end
    wait_tick();
    n_tests++;
    if (sample_tick !== 1'b1 || dac_out !== 8'h80) begin
      n_fail++; $display("FAIL basic_prime_tick: tick %b dac %h expected 1/80", sample_tick, dac_out);
    end
    next_cycle();
    n_tests++;
    if (dac_out !== 8'h10 || fifo_level !== LW'(1)) begin
      n_fail++; $display("FAIL basic_first: dac %h level %0d expected 10/1", dac_out, fifo_level);
    end
    wait_tick(); next_cycle();
    n_tests++;
    if (dac_out !== 8'hF0 || fifo_level !== LW'(0)) begin
      n_fail++; $display("FAIL basic_second: dac %h level %0d expected f0/0", dac_out, fifo_level);
    end
  endtask

  task automatic test_back_to_back();
    int held_err = 0;
    int k = 0;
    do_reset();
    for (int i = 0; i < 5; i++) bb_data[i] = 8'($urandom_range(0, 255));
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin s_data = bb_data[i]; next_cycle(); end
    n_tests++;
    if (s_ready !== 1'b0 || fifo_level !== LW'(4)) begin
      n_fail++; $display("FAIL bb_full: ready %b level %0d expected 0/4", s_ready, fifo_level);
    end
    s_data = bb_data[4];
    while (!m_tick() && k < 2 * (DIV + 1)) begin
      if (s_ready !== 1'b0) held_err++;
      next_cycle();
      k++;
    end
    n_tests++; if (held_err != 0) begin n_fail++; $display("FAIL bb_held: ready high %0d cycles expected 0", held_err); end
    n_tests++; if (sample_tick !== 1'b1) begin n_fail++; $display("FAIL bb_tick: got %b expected 1", sample_tick); end
    next_cycle();
    n_tests++;
    if (fifo_level !== LW'(3) || s_ready !== 1'b1 || dac_out !== bb_data[0]) begin
      n_fail++; $display("FAIL bb_after_pop: level %0d ready %b dac %h expected 3/1/%h",
                         fifo_level, s_ready, dac_out, bb_data[0]);
    end
    next_cycle();
    s_valid = 1'b0;
    n_tests++;
    if (fifo_level !== LW'(4) || s_ready !== 1'b0) begin
      n_fail++; $display("FAIL bb_fifth: level %0d ready %b expected 4/0", fifo_level, s_ready);
    end
  endtask

  // Continues from test_back_to_back: four samples buffered, playing.
  task automatic test_underrun();
    logic [7:0] x, y;
    for (int i = 1; i < 5; i++) begin
      wait_tick(); next_cycle();
      n_tests++;
      if (dac_out !== bb_data[i]) begin
        n_fail++; $display("FAIL drain_%0d: dac %h expected %h", i, dac_out, bb_data[i]);
      end
    end
    wait_tick();
    n_tests++;
    if (underrun !== 1'b1 || sample_tick !== 1'b1 || fifo_level !== LW'(0)) begin
      n_fail++; $display("FAIL under_pulse: underrun %b tick %b level %0d expected 1/1/0", underrun, sample_tick, fifo_level);
    end
    next_cycle();
    n_tests++;
    if (underrun !== 1'b0 || dac_out !== bb_data[4]) begin
      n_fail++; $display("FAIL under_hold: underrun %b dac %h expected 0/%h", underrun, dac_out, bb_data[4]);
    end
    x = bb_data[4] ^ 8'h5A;
    y = x + 8'h11;
    s_valid = 1'b1; s_data = x; next_cycle(); s_valid = 1'b0;
    wait_tick();
    n_tests++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL under_fill_tick: underrun %b expected 0", underrun); end
    next_cycle();
    n_tests++;
    if (dac_out !== bb_data[4] || fifo_level !== LW'(1)) begin
      n_fail++; $display("FAIL under_fill_hold: dac %h level %0d expected %h/1", dac_out, fifo_level, bb_data[4]);
    end
    s_valid = 1'b1; s_data = y; next_cycle(); s_valid = 1'b0;
    wait_tick(); next_cycle();
    n_tests++;
    if (dac_out !== x || fifo_level !== LW'(1)) begin
      n_fail++; $display("FAIL under_resume: dac %h level %0d expected %h/1", dac_out, fifo_level, x);
    end
  endtask

  task automatic test_mute();
    do_reset();
    s_valid = 1'b1; s_data = 8'hFF;
    repeat (4) next_cycle();
    s_valid = 1'b0;
    wait_tick(); next_cycle();
    n_tests++;
    if (dac_out !== 8'hFF || fifo_level !== LW'(3)) begin
      n_fail++; $display("FAIL mute_pre: dac %h level %0d expected ff/3", dac_out, fifo_level);
    end
    mute = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_tick(); next_cycle();
      n_tests++;
      if (dac_out !== 8'h80 || fifo_level !== LW'(2 - i)) begin
        n_fail++; $display("FAIL mute_%0d: dac %h level %0d expected 80/%0d", i, dac_out, fifo_level, 2 - i);
      end
    end
    mute = 1'b0;
    wait_tick(); next_cycle();
    n_tests++;
    if (dac_out !== 8'hFF || fifo_level !== LW'(0)) begin
      n_fail++; $display("FAIL mute_release: dac %h level %0d expected ff/0", dac_out, fifo_level);
    end
  endtask

  task automatic test_reset_midplay();
    int c = 1;
    do_reset();
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin s_data = 8'h20 + 8'(i); next_cycle(); end
    s_valid = 1'b0;
    wait_tick(); next_cycle();
    n_tests++; if (dac_out !== 8'h20) begin n_fail++; $display("FAIL midrst_pre: dac %h expected 20", dac_out); end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (dac_out !== 8'h80 || fifo_level !== LW'(0) || s_ready !== 1'b1 || sample_tick !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: dac %h level %0d ready %b tick %b expected 80/0/1/0",
                         dac_out, fifo_level, s_ready, sample_tick);
    end
    model_reset();
    repeat (2) next_cycle();
    reset_n = 1'b1;
    while (sample_tick !== 1'b1 && c <= 300) begin next_cycle(); c++; end
    n_tests++; if (c != 201) begin n_fail++; $display("FAIL midrst_first_tick: cycle %0d expected 201", c); end
    n_tests++;
    if (dac_out !== 8'h80 || underrun !== 1'b0 || fifo_level !== LW'(0)) begin
      n_fail++; $display("FAIL midrst_empty: dac %h underrun %b level %0d expected 80/0/0", dac_out, underrun, fifo_level);
    end
  endtask

  task automatic test_random();
    int unsigned pct;
    int errs = 0;
    logic [10+LW:0] exp_v, got_v;
    do_reset();
    for (int c = 0; c < 6000 && errs < 10; c++) begin
      exp_v = {m_dac, m_tick(), m_und(), LW'(m_q.size()), (m_q.size() < DEPTH)};
      got_v = {dac_out, sample_tick, underrun, fifo_level, s_ready};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++; errs++;
        $display("FAIL rand cycle %0d: got dac %h tick %b und %b lvl %0d rdy %b, expected dac %h tick %b und %b lvl %0d rdy %b",
                 c, dac_out, sample_tick, underrun, fifo_level, s_ready,
                 m_dac, m_tick(), m_und(), m_q.size(), (m_q.size() < DEPTH));
      end
      case ((c / 1000) % 3)
        0:       pct = 4;
        1:       pct = 12;
        default: pct = 300;
      endcase
      s_valid = ($urandom_range(0, 999) < pct);
      s_data  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 299) == 0) mute = ~mute;
      if (c == 3500) reset_n = 1'b0;
      if (c == 3503) reset_n = 1'b1;
      next_cycle();
    end
    reset_n = 1'b1;
    mute    = 1'b0;
    s_valid = 1'b0;
  endtask

  initial begin
    @(negedge CLOCK_25);
    #1;
    test_reset();
    test_idle_ticks();
    test_play_basic();
    test_back_to_back();
    test_underrun();
    test_mute();
    test_reset_midplay();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
